// File: rtl/reg_fifo.sv
// reg_fifo: register-based synchronous FIFO with valid/ready handshake on both
// sides and first-word-fall-through head output.
// Optional feature macro: REG_FIFO_BYPASS_EN (empty-FIFO combinational bypass).
module reg_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [N-1:0]  enq_data,
  output logic          enq_ready,
  output logic          deq_valid,
  output logic [N-1:0]  deq_data,
  input  logic          deq_ready,
  output logic [AW:0]   count
);

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty;
  logic          full;
  logic          wr_en;
  logic          deq_fire;

  // Status, handshake decode and next-state for storage, pointers and count.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (AW+1)'(DEPTH));
    enq_ready = !full;
    count     = count_q;
`ifdef REG_FIFO_BYPASS_EN
    // Empty FIFO forwards the producer word straight to the consumer; it is
    // only stored when the consumer does not take it this cycle.
    deq_valid = empty ? enq_valid : 1'b1;
    deq_data  = empty ? enq_data : mem_q[rd_ptr_q];
    deq_fire  = !empty && deq_ready;
    wr_en     = enq_valid && !full && !(empty && deq_ready) && !rst;
`else
    deq_valid = !empty;
    deq_data  = mem_q[rd_ptr_q];
    deq_fire  = deq_valid && deq_ready;
    wr_en     = enq_valid && !full && !rst;
`endif

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_en, deq_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage registers; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: directed self-checking bench for reg_fifo (N=8, DEPTH=4).
// Expectations follow REG_FIFO_BYPASS_EN when the bench is built with it.
module tb_reg_fifo;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst;
  logic          enq_valid;
  logic [N-1:0]  enq_data;
  logic          enq_ready;
  logic          deq_valid;
  logic [N-1:0]  deq_data;
  logic          deq_ready;
  logic [AW:0]   count;

  int tests;
  int fails;

  logic         prev_blocked;
  logic [N-1:0] prev_data;

  reg_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producer must hold a word steady while it is being back-pressured.
  always @(posedge clk) begin
    if (!rst && prev_blocked) begin
      assert (enq_valid === 1'b1 && enq_data === prev_data) else begin
        fails++;
        $error("FAIL retract observed=%0b/%0h expected=1/%0h", enq_valid, enq_data, prev_data);
      end
    end
    prev_blocked <= enq_valid && !enq_ready && !rst;
    prev_data    <= enq_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [N-1:0] d, input logic dr);
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    #1;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    prev_blocked = 1'b0;
    prev_data    = '0;
    rst          = 1'b1;
    enq_valid    = 1'b0;
    enq_data     = '0;
    deq_ready    = 1'b0;

    // Reset then idle
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);

    // Fill with back-pressure, fifth word held off
    drive(1'b1, 8'h11, 1'b0); tick(); chk("fill_count1", 32'(count), 32'd1);
    chk("fill_head", 32'(deq_data), 32'h11);
    drive(1'b1, 8'h22, 1'b0); tick(); chk("fill_count2", 32'(count), 32'd2);
    drive(1'b1, 8'h33, 1'b0); tick(); chk("fill_count3", 32'(count), 32'd3);
    drive(1'b1, 8'h44, 1'b0); tick(); chk("fill_count4", 32'(count), 32'd4);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    drive(1'b1, 8'h55, 1'b0); tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_head",  32'(deq_data), 32'h11);
    chk("full_hold_ready", 32'(enq_ready), 32'd0);

    // Drain in order; 0x55 is admitted once a slot opens
    drive(1'b1, 8'h55, 1'b1);
    chk("drain_11", 32'(deq_data), 32'h11);
    tick();
    chk("drain_count_a", 32'(count), 32'd3);
    chk("drain_ready_a", 32'(enq_ready), 32'd1);
    chk("drain_22", 32'(deq_data), 32'h22);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("drain_count_b", 32'(count), 32'd3);
    chk("drain_33", 32'(deq_data), 32'h33);
    tick(); chk("drain_44", 32'(deq_data), 32'h44);
    tick(); chk("drain_55", 32'(deq_data), 32'h55);
    chk("drain_valid_55", 32'(deq_valid), 32'd1);
    tick();
    chk("drain_empty_count", 32'(count), 32'd0);
    chk("drain_empty_valid", 32'(deq_valid), 32'd0);

    // Full plus simultaneous enq/deq: write side blocked that cycle
    drive(1'b1, 8'hC1, 1'b0); tick();
    drive(1'b1, 8'hC2, 1'b0); tick();
    drive(1'b1, 8'hC3, 1'b0); tick();
    drive(1'b1, 8'hC4, 1'b0); tick();
    drive(1'b1, 8'hAA, 1'b1);
    chk("fs_ready_full", 32'(enq_ready), 32'd0);
    chk("fs_head_c1", 32'(deq_data), 32'hC1);
    tick();
    chk("fs_count3", 32'(count), 32'd3);
    chk("fs_ready_next", 32'(enq_ready), 32'd1);
    drive(1'b1, 8'hAA, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("fs_count4", 32'(count), 32'd4);
    chk("fs_c2", 32'(deq_data), 32'hC2); tick();
    chk("fs_c3", 32'(deq_data), 32'hC3); tick();
    chk("fs_c4", 32'(deq_data), 32'hC4); tick();
    chk("fs_aa", 32'(deq_data), 32'hAA); tick();
    chk("fs_empty", 32'(count), 32'd0);

    // Back-to-back streaming of 20 words across several pointer wraps
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) drive(1'b1, 8'(c), 1'b1);
      else        drive(1'b0, 8'h00, 1'b1);
`ifdef REG_FIFO_BYPASS_EN
      chk("stream_count", 32'(count), 32'd0);
      if (c < 20) begin
        chk("stream_valid", 32'(deq_valid), 32'd1);
        chk("stream_data",  32'(deq_data),  32'(c));
      end else begin
        chk("stream_valid_end", 32'(deq_valid), 32'd0);
      end
`else
      if (c == 0) begin
        chk("stream_valid0", 32'(deq_valid), 32'd0);
        chk("stream_count0", 32'(count), 32'd0);
      end else begin
        chk("stream_valid", 32'(deq_valid), 32'd1);
        chk("stream_data",  32'(deq_data),  32'(c - 1));
        chk("stream_count", 32'(count),     32'd1);
      end
`endif
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_end_valid", 32'(deq_valid), 32'd0);

    // Reset mid-operation discards contents and the reset-cycle handshakes
    drive(1'b1, 8'h01, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0); tick();
    drive(1'b1, 8'h03, 1'b0); tick();
    chk("mid_count3", 32'(count), 32'd3);
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1); tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(deq_valid), 32'd0);
    chk("mid_rst_ready", 32'(enq_ready), 32'd1);
    drive(1'b1, 8'h5A, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("mid_first_valid", 32'(deq_valid), 32'd1);
    chk("mid_first_data",  32'(deq_data),  32'h5A);
    chk("mid_first_count", 32'(count),     32'd1);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("mid_drained", 32'(count), 32'd0);

    // Empty FIFO with simultaneous enq and deq: latency / bypass
    drive(1'b1, 8'h7E, 1'b1);
`ifdef REG_FIFO_BYPASS_EN
    chk("byp_valid", 32'(deq_valid), 32'd1);
    chk("byp_data",  32'(deq_data),  32'h7E);
    chk("byp_count", 32'(count),     32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("byp_after_count", 32'(count), 32'd0);
    chk("byp_after_valid", 32'(deq_valid), 32'd0);
`else
    chk("lat_valid0", 32'(deq_valid), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("lat_valid1", 32'(deq_valid), 32'd1);
    chk("lat_data1",  32'(deq_data),  32'h7E);
    chk("lat_count1", 32'(count),     32'd1);
    tick();
    chk("lat_count_end", 32'(count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
